// File: rtl/cap_line_writer_pkg.sv
// Shared types and widths for the capture line writer: FSM states and bus widths.
package cap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    REQ,
    DATA,
    DONE,
    WAIT_CLR
  } state_t;

  localparam int RGB_W      = 12;
  localparam int RAM_DATA_W = 16;
  localparam int LINE_W     = 9;
  localparam int LEN_W      = 9;

endpackage

// File: rtl/cap_line_writer_if.sv
// SDRAM burst-write port: request/address/length handshake plus per-word data strobe.
interface cap_line_writer_if #(
  parameter int ADDR_W = 20
) ();
  import cap_pkg::*;

  logic                  wr_req;
  logic [ADDR_W-1:0]     wr_addr;
  logic [LEN_W-1:0]      wr_len;
  logic                  wr_ack;
  logic                  wr_data_req;
  logic [RAM_DATA_W-1:0] wr_data;

  modport master (
    output wr_req, wr_addr, wr_len, wr_data,
    input  wr_ack, wr_data_req
  );

  modport slave (
    input  wr_req, wr_addr, wr_len, wr_data,
    output wr_ack, wr_data_req
  );

endinterface

// File: rtl/cap_line_writer_burst_split.sv
// Column / remaining-word / in-burst counters that carve one line into bursts.
module cap_burst_split
  import cap_pkg::*;
#(
  parameter int COL_W     = 10,
  parameter int BURST_LEN = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [COL_W:0]   i_words,
  input  logic             i_burst_start,
  input  logic             i_take,
  output logic [COL_W-1:0] o_col,
  output logic [LEN_W-1:0] o_len,
  output logic             o_last_in_burst,
  output logic             o_last_in_line
);

  localparam int REM_W = COL_W + 1;

  logic [COL_W-1:0] r_col;
  logic [REM_W-1:0] r_rem;
  logic [LEN_W-1:0] r_bcnt;

  // r_rem only drops at burst boundaries, so o_len stays frozen for the whole burst.
  assign o_len           = (r_rem > REM_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(r_rem);
  assign o_last_in_burst = (r_bcnt + LEN_W'(1)) == o_len;
  assign o_last_in_line  = o_last_in_burst && (r_rem == REM_W'(o_len));
  assign o_col           = r_col;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_col  <= '0;
      r_rem  <= '0;
      r_bcnt <= '0;
    end else if (i_load) begin
      r_col  <= '0;
      r_rem  <= i_words;
      r_bcnt <= '0;
    end else begin
      if (i_burst_start) r_bcnt <= '0;
      if (i_take) begin
        r_col  <= r_col + COL_W'(1);
        r_bcnt <= r_bcnt + LEN_W'(1);
        if (o_last_in_burst) r_rem <= r_rem - REM_W'(o_len);
      end
    end
  end

endmodule

// File: rtl/cap_line_writer.sv
// Moves one captured line per FIFO event into SDRAM as bursts, alternating frame buffers.
module cap_line_writer
  import cap_pkg::*;
#(
  parameter int SCR_SIZE_BIT = 10,
  parameter int COL_W        = 10,
  parameter int BURST_LEN    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_fifo_active,
  input  logic [LINE_W-1:0]     i_fifo_line,
  input  logic [RGB_W-1:0]      i_fifo_data,
  output logic                  o_fifo_next,
  output logic                  o_fifo_reset,
  input  logic [SCR_SIZE_BIT:0] i_x_size,
  input  logic [SCR_SIZE_BIT:0] i_y_size,
  cap_line_writer_if.master     wr,
  output logic                  o_frame_buf,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  localparam int X_W       = SCR_SIZE_BIT + 2;
  localparam int REM_W     = COL_W + 1;
  localparam int MAX_WORDS = 1 << COL_W;

  state_t            r_state, w_next;
  logic [LINE_W-1:0] r_line;
  logic              r_frame_buf;

  logic              w_load, w_burst_start, w_take, w_req, w_frame_end;
  logic [X_W-1:0]    w_x_words;
  logic [REM_W-1:0]  w_line_words;
  logic [COL_W-1:0]  w_col;
  logic [LEN_W-1:0]  w_len;
  logic              w_last_in_burst, w_last_in_line;
  logic              w_unused;

  // Words beyond the column space are left in the FIFO and discarded by the line release.
  assign w_x_words    = {1'b0, i_x_size} + X_W'(1);
  assign w_line_words = (32'(w_x_words) > 32'(MAX_WORDS)) ? REM_W'(MAX_WORDS) : REM_W'(w_x_words);
  assign w_frame_end  = (r_state == DONE) && (r_line == i_y_size[LINE_W-1:0]);
  assign w_unused     = &{1'b0, i_y_size[SCR_SIZE_BIT:LINE_W]};

  cap_burst_split #(
    .COL_W     (COL_W),
    .BURST_LEN (BURST_LEN)
  ) u_split (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_load          (w_load),
    .i_words         (w_line_words),
    .i_burst_start   (w_burst_start),
    .i_take          (w_take),
    .o_col           (w_col),
    .o_len           (w_len),
    .o_last_in_burst (w_last_in_burst),
    .o_last_in_line  (w_last_in_line)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_line      <= '0;
      r_frame_buf <= 1'b0;
    end else begin
      if (r_state == LATCH) r_line <= i_fifo_line;
      if (w_frame_end)      r_frame_buf <= ~r_frame_buf;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next        = r_state;
    w_load        = 1'b0;
    w_burst_start = 1'b0;
    w_take        = 1'b0;
    w_req         = 1'b0;
    o_fifo_next   = 1'b0;
    o_fifo_reset  = 1'b0;
    o_frame_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_fifo_active && i_enable) w_next = LATCH;
      end
      LATCH: begin
        w_load = 1'b1;
        w_next = REQ;
      end
      REQ: begin
        // Data strobes arriving with the ack are deliberately ignored.
        w_req = 1'b1;
        if (wr.wr_ack) begin
          w_burst_start = 1'b1;
          w_next        = DATA;
        end
      end
      DATA: begin
        if (wr.wr_data_req) begin
          w_take      = 1'b1;
          o_fifo_next = 1'b1;
          if (w_last_in_burst) w_next = w_last_in_line ? DONE : REQ;
        end
      end
      DONE: begin
        o_fifo_reset = 1'b1;
        o_frame_done = w_frame_end;
        w_next       = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!i_fifo_active) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign wr.wr_req  = w_req;
  assign wr.wr_addr = {r_frame_buf, r_line, w_col};
  assign wr.wr_len  = w_len;
  assign wr.wr_data = {{(RAM_DATA_W - RGB_W){1'b0}}, i_fifo_data};
  assign o_frame_buf = r_frame_buf;
  assign o_busy      = (r_state != IDLE);

endmodule
